// File: rtl/seq_multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Holds the controller state encoding, the operation encoding and the
// default operand width used by seq_multdiv and its bench.
package seq_multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

endpackage

// File: rtl/seq_multdiv_twos_abs.sv
// twos_abs: WIDTH-bit conditional two's-complement negate.
// Driving i_negate with the operand's sign bit yields its magnitude (the most
// negative value maps onto itself, which read as unsigned is its magnitude);
// driving it with the wanted result sign turns a magnitude into a signed value.
module twos_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    // Negate when asked, otherwise pass the value straight through
    always_comb begin
        o_value = i_value;
        if (i_negate) begin
            o_value = ~i_value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_multdiv.sv
// seq_multdiv: sequential signed multiplier / divider.
// Operands are reduced to magnitudes at start, iterated one bit per clock for
// WIDTH clocks (shift-add multiply, restoring divide), then sign-corrected as
// the result is registered. Optional build macro SEQ_MULTDIV_EARLY_DIV0_EN makes
// a divide by zero skip the iteration and complete one cycle after start.
module seq_multdiv
    import seq_multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    op_t              r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opB;
    logic             r_negResult;
    logic             r_divZero;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_exception;
    logic             r_resultRdy;
    logic             r_busy;

    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic               w_start;
    op_t                w_startOp;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH-1:0]   w_nextHi;
    logic [WIDTH-1:0]   w_nextLo;
    logic [2*WIDTH-1:0] w_signedProd;
    logic [WIDTH-1:0]   w_signedQuot;
    logic [WIDTH:0]     w_prodTop;
    logic               w_prodFits;
    logic               w_lastStep;

    assign w_start    = ctrl_MULT | ctrl_DIV;
    assign w_startOp  = ctrl_MULT ? OP_MULT : OP_DIV;
    assign w_lastStep = (r_count == CW'(WIDTH - 1));
    assign w_prodTop  = w_signedProd[2*WIDTH-1:WIDTH-1];
    assign w_prodFits = (&w_prodTop) | ~(|w_prodTop);

    twos_abs #(.WIDTH(WIDTH)) u_absA (
        .i_value  (data_operandA),
        .i_negate (data_operandA[WIDTH-1]),
        .o_value  (w_absA)
    );

    twos_abs #(.WIDTH(WIDTH)) u_absB (
        .i_value  (data_operandB),
        .i_negate (data_operandB[WIDTH-1]),
        .o_value  (w_absB)
    );

    twos_abs #(.WIDTH(2 * WIDTH)) u_fixProd (
        .i_value  ({w_nextHi, w_nextLo}),
        .i_negate (r_negResult),
        .o_value  (w_signedProd)
    );

    twos_abs #(.WIDTH(WIDTH)) u_fixQuot (
        .i_value  (w_nextLo),
        .i_negate (r_negResult),
        .o_value  (w_signedQuot)
    );

    // One iteration step: r_hi is the partial product / partial remainder, r_lo the multiplier / quotient
    always_comb begin
        w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opB} : {(WIDTH+1){1'b0}});
        w_shifted = {r_hi, r_lo[WIDTH-1]};
        w_nextHi  = r_hi;
        w_nextLo  = r_lo;
        if (r_op == OP_MULT) begin
            w_nextHi = w_sum[WIDTH:1];
            w_nextLo = {w_sum[0], r_lo[WIDTH-1:1]};
        end else if (w_shifted >= {1'b0, r_opB}) begin
            w_nextHi = WIDTH'(w_shifted - {1'b0, r_opB});
            w_nextLo = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_nextHi = w_shifted[WIDTH-1:0];
            w_nextLo = {r_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Controller FSM with datapath registers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_MULT;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opB       <= '0;
            r_negResult <= 1'b0;
            r_divZero   <= 1'b0;
            r_count     <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_resultRdy <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_resultRdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_op        <= w_startOp;
                        r_hi        <= '0;
                        r_lo        <= w_absA;
                        r_opB       <= w_absB;
                        r_negResult <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        r_divZero   <= (data_operandB == '0);
                        r_count     <= '0;
                        r_busy      <= 1'b1;
`ifdef SEQ_MULTDIV_EARLY_DIV0_EN
                        if (w_startOp == OP_DIV && data_operandB == '0) begin
                            r_state     <= ST_DONE;
                            r_result    <= '0;
                            r_exception <= 1'b1;
                            r_resultRdy <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
`else
                        r_state <= ST_RUN;
`endif
                    end
                end
                ST_RUN: begin
                    r_hi    <= w_nextHi;
                    r_lo    <= w_nextLo;
                    r_count <= r_count + CW'(1);
                    if (w_lastStep) begin
                        r_state     <= ST_DONE;
                        r_resultRdy <= 1'b1;
                        if (r_op == OP_MULT) begin
                            r_result    <= w_signedProd[WIDTH-1:0];
                            r_exception <= ~w_prodFits;
                        end else if (r_divZero) begin
                            r_result    <= '0;
                            r_exception <= 1'b1;
                        end else begin
                            r_result    <= w_signedQuot;
                            r_exception <= w_nextLo[WIDTH-1] & ~r_negResult;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = r_resultRdy;
    assign busy           = r_busy;

endmodule

// File: tb/tb_seq_multdiv.sv
// Directed bench for seq_multdiv at WIDTH=32. Latency is counted in falling
// edges after the start edge, so a completion registered at the start edge
// itself reads as 1 and a full-length operation reads as WIDTH+1.
module tb_seq_multdiv;

    localparam int WIDTH = 32;
    localparam int LIMIT = 80;

`ifdef SEQ_MULTDIV_EARLY_DIV0_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = WIDTH + 1;
`endif

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    int compared   = 0;
    int mismatched = 0;

    seq_multdiv #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Free-running clock, 10 time units per period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one start pulse, scramble the operands afterwards, and wait (bounded) for RDY
    task automatic applyStimulus(input logic m, input logic d,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output logic [WIDTH-1:0] res, output logic exc, output int lat);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = ~a;
        data_operandB = b + 32'd3;
        lat = 1;
        while (data_resultRDY !== 1'b1 && lat < LIMIT) begin
            @(negedge clock);
            lat++;
        end
        res = data_result;
        exc = data_exception;
    endtask

    // Linear sequence of directed steps
    initial begin
        logic [WIDTH-1:0] res;
        logic             exc;
        int               lat;
        int               rdyCount;
        int               rdyAt;
        int               busyLow;
        logic             busyAfter;
        logic [WIDTH-1:0] resSeen;

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset_result", 64'(data_result), 64'h0);
        checkOutput("reset_exception", 64'(data_exception), 64'h0);
        checkOutput("reset_rdy", 64'(data_resultRDY), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b0, 32'd6, 32'hFFFF_FFF9, res, exc, lat);
        checkOutput("mult_6x-7_result", 64'(res), 64'hFFFF_FFD6);
        checkOutput("mult_6x-7_exc", 64'(exc), 64'h0);
        checkOutput("mult_6x-7_latency", 64'(lat), 64'(WIDTH + 1));

        applyStimulus(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, res, exc, lat);
        checkOutput("div_100/-7_result", 64'(res), 64'hFFFF_FFF2);
        checkOutput("div_100/-7_exc", 64'(exc), 64'h0);
        checkOutput("div_100/-7_latency", 64'(lat), 64'(WIDTH + 1));

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, res, exc, lat);
        checkOutput("div_-100/7_result", 64'(res), 64'hFFFF_FFF2);
        checkOutput("div_-100/7_exc", 64'(exc), 64'h0);

        applyStimulus(1'b0, 1'b1, 32'd5, 32'd0, res, exc, lat);
        checkOutput("div_5/0_result", 64'(res), 64'h0);
        checkOutput("div_5/0_exc", 64'(exc), 64'h1);
        checkOutput("div_5/0_latency", 64'(lat), 64'(DIV0_LAT));

        applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, res, exc, lat);
        checkOutput("mult_overflow_result", 64'(res), 64'h0);
        checkOutput("mult_overflow_exc", 64'(exc), 64'h1);

        applyStimulus(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, res, exc, lat);
        checkOutput("mult_max_x1_result", 64'(res), 64'h7FFF_FFFF);
        checkOutput("mult_max_x1_exc", 64'(exc), 64'h0);

        applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, exc, lat);
        checkOutput("div_min/-1_result", 64'(res), 64'h8000_0000);
        checkOutput("div_min/-1_exc", 64'(exc), 64'h1);

        applyStimulus(1'b1, 1'b1, 32'd7, 32'd3, res, exc, lat);
        checkOutput("mult_priority_result", 64'(res), 64'd21);
        checkOutput("mult_priority_latency", 64'(lat), 64'(WIDTH + 1));

        @(negedge clock);
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        rdyCount  = 0;
        rdyAt     = 0;
        busyLow   = 0;
        busyAfter = 1'b1;
        resSeen   = '0;
        for (int k = 1; k <= 45; k++) begin
            ctrl_DIV = (k == 5);
            if (rdyCount > 0 && k == rdyAt + 1) begin
                busyAfter = busy;
            end
            if (data_resultRDY === 1'b1) begin
                rdyCount++;
                rdyAt   = k;
                resSeen = data_result;
            end
            if (rdyCount == 0 && busy !== 1'b1) begin
                busyLow++;
            end
            @(negedge clock);
        end
        ctrl_DIV = 1'b0;
        checkOutput("ignore_div_rdy_count", 64'(rdyCount), 64'd1);
        checkOutput("ignore_div_rdy_at", 64'(rdyAt), 64'(WIDTH + 1));
        checkOutput("ignore_div_result", 64'(resSeen), 64'd12);
        checkOutput("ignore_div_busy_low_before_rdy", 64'(busyLow), 64'd0);
        checkOutput("ignore_div_busy_after_rdy", 64'(busyAfter), 64'd0);

        data_operandA = 32'd5;
        data_operandB = 32'd5;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_result", 64'(data_result), 64'h0);
        checkOutput("abort_exception", 64'(data_exception), 64'h0);
        checkOutput("abort_rdy", 64'(data_resultRDY), 64'h0);
        checkOutput("abort_busy", 64'(busy), 64'h0);
        reset    = 1'b0;
        rdyCount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                rdyCount++;
            end
        end
        checkOutput("abort_no_rdy", 64'(rdyCount), 64'd0);

        applyStimulus(1'b1, 1'b0, 32'd2, 32'd2, res, exc, lat);
        checkOutput("after_abort_result", 64'(res), 64'd4);
        checkOutput("after_abort_exc", 64'(exc), 64'h0);
        checkOutput("after_abort_latency", 64'(lat), 64'(WIDTH + 1));

        @(negedge clock);
        @(negedge clock);
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        @(negedge clock);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        @(negedge clock);
        checkOutput("start_during_reset_busy", 64'(busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_multdiv.md
SEQ_MULTDIV -- requirements
Module: seq_multdiv

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: data_operandA  input  WIDTH  signed multiplicand/dividend, sampled on start.
REQ-005 SHALL have port: data_operandB  input  WIDTH  signed multiplier/divisor, sampled on start.
REQ-006 SHALL have port: ctrl_MULT  input  1  single-cycle start pulse for a multiply.
REQ-007 SHALL have port: ctrl_DIV  input  1  single-cycle start pulse for a divide.
REQ-008 SHALL have port: data_result  output  WIDTH  signed result, valid while data_resultRDY=1.
REQ-009 SHALL have port: data_exception  output  1  error flag, valid while data_resultRDY=1.
REQ-010 SHALL have port: data_resultRDY  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: busy  output  1  high from the cycle after start until data_resultRDY is high, inclusive.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; a start is accepted only in IDLE.
REQ-013 SHALL, on an accepted start, latch both operands and the op; later operand changes have no effect.
REQ-014 SHALL give ctrl_MULT priority when ctrl_MULT and ctrl_DIV are high in the same cycle.
REQ-015 SHALL ignore ctrl_MULT/ctrl_DIV while in RUN or DONE; no queuing.
REQ-016 SHALL iterate on magnitudes (radix-2 shift-add for multiply, restoring for divide) for exactly WIDTH cycles in RUN, then apply the sign.
REQ-017 SHALL assert data_resultRDY for exactly one cycle, WIDTH+1 cycles after the start edge, in state DONE.
REQ-018 SHALL accept a new start in the cycle immediately after DONE (back-to-back spacing WIDTH+2 cycles).
REQ-019 SHALL return, for multiply, the low WIDTH bits of the 2*WIDTH signed product, with data_exception=1 iff the product does not fit in WIDTH signed bits.
REQ-020 SHALL return, for divide, the quotient truncated toward zero; the remainder is discarded.
REQ-021 SHALL, for a divide by zero, give data_result=0 and data_exception=1.
REQ-022 SHALL, for MIN/-1, give data_result=MIN and data_exception=1.
REQ-023 SHALL hold data_result and data_exception at their last values outside DONE; they are meaningful only while data_resultRDY=1.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, force IDLE and data_result=0, data_exception=0, data_resultRDY=0, busy=0, including mid-RUN; the aborted operation is lost.
REQ-025 SHALL ignore a start asserted in the same cycle as reset.

Configuration
REQ-026 SHALL support macro SEQ_MULTDIV_EARLY_DIV0_EN.
REQ-027 SHALL, with SEQ_MULTDIV_EARLY_DIV0_EN defined, detect divisor==0 at start and go straight to DONE, so data_resultRDY is asserted 1 cycle after the start edge.
REQ-028 SHALL, without the macro, run divide-by-zero for the full WIDTH+1 latency; result values per REQ-021 are identical in both builds.

Structure
REQ-029 SHALL put the FSM state enum, the op enum (OP_MULT, OP_DIV) and the default WIDTH constant in shared package seq_multdiv_pkg.
REQ-030 SHALL use one sub-module, twos_abs (WIDTH-parametrised magnitude/negate), instanced for operand conditioning and result sign fix-up.

Verification (WIDTH=32)
REQ-031 SHALL check: MULT 6 x -7 -> data_result=-42, exception=0, data_resultRDY exactly 33 cycles after start.
REQ-032 SHALL check: DIV 100 / -7 -> -14, exception=0; then DIV -100 / 7 -> -14.
REQ-033 SHALL check: DIV 5 / 0 -> result=0, exception=1, RDY at +33 (macro off) or +1 (macro on).
REQ-034 SHALL check: MULT 0x00010000 x 0x00010000 -> result=0x00000000, exception=1; MULT 0x7FFFFFFF x 1 -> exception=0.
REQ-035 SHALL check: start MULT 3 x 4, pulse ctrl_DIV at +5 -> only one RDY, result=12, busy high until RDY.
REQ-036 SHALL check: reset at +10 of a MULT -> all outputs 0 next cycle, no RDY; a new MULT 2 x 2 then returns 4.
